led_mode_ctrl: RTL

- Controller that sequences a bank of LEDs through selectable display modes: off, on, blink, running light and breathing (PWM).
- Accepts mode commands from a requester (key decoder or host logic) over a valid/ready handshake.
- Applies each new mode only on a tick boundary so patterns never glitch mid-period.
- Sits between the user-input logic and the board LED pins, replacing direct single-LED drivers.

---
 rtl/led_mode_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// LED display-mode controller: accepts mode commands over valid/ready and
// applies them on pattern tick boundaries (off, on, blink, running light, PWM breath).
module led_mode_ctrl #(
    parameter int unsigned LED_W       = 4,
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned PWM_STEPS   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_mode,
    output logic             cmd_ready,
    output logic             cmd_err,
    output logic [2:0]       cur_mode,
    output logic             tick,
    output logic [LED_W-1:0] led
);

    localparam int unsigned TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PW = (PWM_STEPS > 2) ? $clog2(PWM_STEPS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_CYCLES - 2);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_STEPS - 1);
    localparam logic [PW-1:0] DUTY_TOP  = PW'(PWM_STEPS - 2);
    localparam logic [PW-1:0] DUTY_ONE  = PW'(1);

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_ON     = 3'd1;
    localparam logic [2:0] MODE_BLINK  = 3'd2;
    localparam logic [2:0] MODE_RUN    = 3'd3;
    localparam logic [2:0] MODE_BREATH = 3'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_tick_cnt;
    logic [2:0]       r_pend_mode;
    logic             r_phase;
    logic [LED_W-1:0] r_run_ptr;
    logic [PW-1:0]    r_pwm_cnt;
    logic [PW-1:0]    r_duty;
    logic             r_dir_up;

    logic             w_apply;
    logic             w_pwm_wrap;
    logic [LED_W-1:0] w_ptr_rot;

    assign w_apply    = (r_state == ST_PEND) && tick;
    assign w_pwm_wrap = (r_pwm_cnt == PWM_LAST);
    // Rotate left; with a single LED this degenerates to holding the bit.
    assign w_ptr_rot  = LED_W'((r_run_ptr << 1) | (r_run_ptr >> (LED_W - 1)));

    // Free-running tick counter; tick is registered so it coincides with the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            tick       <= 1'b0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
            tick       <= (r_tick_cnt == TICK_PRE);
        end
    end

    // Command handshake: latch a legal mode, hold it until the next tick boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pend_mode <= MODE_OFF;
            cur_mode    <= MODE_OFF;
            cmd_ready   <= 1'b1;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_mode > MODE_BREATH) begin
                            cmd_err <= 1'b1;
                        end else begin
                            r_pend_mode <= cmd_mode;
                            r_state     <= ST_PEND;
                            cmd_ready   <= 1'b0;
                        end
                    end
                end
                ST_PEND: begin
                    if (tick) begin
                        cur_mode  <= r_pend_mode;
                        r_state   <= ST_RUN;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Pattern state: restarts on every mode apply, otherwise advances on ticks / PWM wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= 1'b0;
            r_run_ptr <= LED_W'(1);
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_dir_up  <= 1'b1;
        end else if (w_apply) begin
            r_phase   <= 1'b1;
            r_run_ptr <= LED_W'(1);
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_dir_up  <= 1'b1;
        end else begin
            if (tick) begin
                r_phase   <= ~r_phase;
                r_run_ptr <= w_ptr_rot;
            end
            r_pwm_cnt <= w_pwm_wrap ? '0 : r_pwm_cnt + PW'(1);
            if (w_pwm_wrap) begin
                if (r_dir_up) begin
                    r_duty <= r_duty + PW'(1);
                    if (r_duty == DUTY_TOP) begin
                        r_dir_up <= 1'b0;
                    end
                end else begin
                    r_duty <= r_duty - PW'(1);
                    if (r_duty == DUTY_ONE) begin
                        r_dir_up <= 1'b1;
                    end
                end
            end
        end
    end

    // LED drive, one cycle behind the pattern state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            case (cur_mode)
                MODE_OFF:    led <= '0;
                MODE_ON:     led <= '1;
                MODE_BLINK:  led <= {LED_W{r_phase}};
                MODE_RUN:    led <= r_run_ptr;
                MODE_BREATH: led <= {LED_W{(r_pwm_cnt < r_duty)}};
                default:     led <= '0;
            endcase
        end
    end

endmodule
